control_fsm: RTL
================

# control_fsm

Parametrised, registered successor to the top-level instruction control unit. It decodes the opcode field of the fetched instruction into datapath strobes and gates the program counter through a start/done handshake with the test harness. It adds three things the single-cycle controller lacks: multi-cycle memory stalls, a run-cycle counter, and a watchdog timeout. It sits between instruction ROM and datapath (accumulator, register file, data memory, PC).

## Interface
- INSTR_W, 9: instruction width
- OP_W, 5: opcode width; opcode is instruction[INSTR_W-1 -: OP_W]
- MEM_LAT, 1: total cycles occupied by loadm/storem (≥1)
- CNT_W, 16: cycle counter width
- MAX_CYCLES, 0: watchdog limit in run cycles; 0 disables
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instruction  in  INSTR_W  current instruction from ROM
- req  in  1  start/restart request from harness
- alu_op  out  OP_W  opcode field, combinational passthrough
- reg_write_enable, acc_write_enable, dat_write_enable, compare_enable, reljump_enable, absjump_enable  out  1 each  datapath strobes
- acc_src  out  1  0 = memory, 1 = ALU
- pc_reset  out  1  PC to start address
- pc_enable  out  1  PC advance/jump this cycle
- done  out  1  program finished / idle
- timeout  out  1  sticky; watchdog fired
- cycle_count  out  CNT_W  run cycles since last req

## Operation
- States: IDLE, RUN, WAIT. Strobes are combinational from state, opcode and wait counter. Outside RUN/WAIT, all strobes are 0 and acc_src is 1.
- Opcode map (RUN, non-memory, single cycle, pc_enable=1):
  - 0–16 ALU: acc_write_enable
  - 18 loadv: acc_write_enable
  - 20 storev: reg_write_enable
  - 21 slt: acc_write_enable
  - 22 beq: compare_enable + reljump_enable
  - 23 rb: reljump_enable
  - 24 ab: absjump_enable
  - 25–30: no-op, pc_enable=1
  - 31 done: all strobes 0, pc_enable=0, next state IDLE
- Memory ops:
  - 17 loadm: acc_src=0 for every cycle of the op; acc_write_enable and pc_enable on the final cycle only.
  - 19 storem: dat_write_enable and pc_enable on the final cycle only (single pulse).
  - MEM_LAT=1: completes in RUN, identical to the single-cycle controller.
  - MEM_LAT>1: RUN cycle is non-final, then WAIT with wcnt loaded to MEM_LAT-2. WAIT decrements; final cycle is wcnt==0, then return to RUN.
- req (any state, including mid-WAIT):
  - pc_reset=req combinationally.
  - All strobes and pc_enable forced 0 that cycle.
  - Next state RUN; cycle_count, wcnt and timeout cleared.
- cycle_count increments each RUN/WAIT cycle without req, and saturates at all-ones.
- Watchdog: in RUN/WAIT with MAX_CYCLES≠0 and cycle_count == MAX_CYCLES-1:
  - Strobes and pc_enable forced 0.
  - Next state IDLE; timeout set.
  - A done opcode in the same cycle still goes to IDLE, and timeout is set anyway.
- done = (state==IDLE), registered.

## Timing
- Reset outputs: state IDLE, done=1, timeout=0, cycle_count=0, pc_enable=0, all strobes 0, acc_src=1. pc_reset follows req even during reset.
- reset has priority over req.
- req at edge N → RUN from N+1. First instruction executes in cycle N+1 (PC was reset at edge N). done falls at N+1.
- Done opcode in cycle K → done=1 from K+1. cycle_count holds its final value until the next req.
- Memory op latency is exactly MEM_LAT cycles; the PC holds for MEM_LAT-1 of them.
- Zero-cycle throughput loss for non-memory ops.

## Structure
- Package control_pkg: opcode localparams (OP_LOADM=17, OP_LOADV=18, OP_STOREM=19, OP_STOREV=20, OP_SLT=21, OP_BEQ=22, OP_RB=23, OP_AB=24, OP_DONE=31) and the state enum typedef.
- No sub-module: wait counter and cycle counter are inline. One always_ff for state/counters, one always_comb for decode.
- Elaboration check: MEM_LAT ≥ 1.

## Test plan
- Reset then idle: done=1, pc_enable=0, cycle_count=0. Pulse req, then ALU op 5 → pc_enable=1 and acc_write_enable=1 in the cycle after req.
- MEM_LAT=3, storem:
  - dat_write_enable high exactly 1 cycle, the 3rd.
  - pc_enable low for 2 cycles, high on the 3rd.
  - cycle_count advances by 3.
- MEM_LAT=3, loadm: acc_src=0 for all 3 cycles; acc_write_enable only on the 3rd.
- Program ALU, beq, done:
  - compare_enable+reljump_enable in cycle 2.
  - done=1 from cycle 4.
  - pc_enable=0 during the done cycle; cycle_count=3.
- req asserted mid-WAIT → no dat_write_enable pulse; pc_reset=1 that cycle. Next cycle: RUN, cycle_count=0.
- MAX_CYCLES=10, infinite rb loop:
  - done and timeout rise at cycle 11 after req.
  - Next req clears timeout.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: opcode map and controller states shared by control_fsm and its bus
package control_pkg;
  localparam int unsigned OP_ALU_MAX = 16;
  localparam int unsigned OP_LOADM   = 17;
  localparam int unsigned OP_LOADV   = 18;
  localparam int unsigned OP_STOREM  = 19;
  localparam int unsigned OP_STOREV  = 20;
  localparam int unsigned OP_SLT     = 21;
  localparam int unsigned OP_BEQ     = 22;
  localparam int unsigned OP_RB      = 23;
  localparam int unsigned OP_AB      = 24;
  localparam int unsigned OP_DONE    = 31;
  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction/handshake inputs and datapath strobe outputs of control_fsm
interface control_fsm_if #(
  parameter int INSTR_W = 9,
  parameter int OP_W    = 5,
  parameter int CNT_W   = 16
);
  logic [INSTR_W-1:0] instruction;
  logic               req;
  logic [OP_W-1:0]    alu_op;
  logic               reg_write_enable;
  logic               acc_write_enable;
  logic               dat_write_enable;
  logic               compare_enable;
  logic               reljump_enable;
  logic               absjump_enable;
  logic               acc_src;
  logic               pc_reset;
  logic               pc_enable;
  logic               done;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_count;
  modport master (
    output instruction, req,
    input  alu_op, reg_write_enable, acc_write_enable, dat_write_enable, compare_enable,
           reljump_enable, absjump_enable, acc_src, pc_reset, pc_enable, done, timeout, cycle_count
  );
  modport slave (
    input  instruction, req,
    output alu_op, reg_write_enable, acc_write_enable, dat_write_enable, compare_enable,
           reljump_enable, absjump_enable, acc_src, pc_reset, pc_enable, done, timeout, cycle_count
  );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: registered instruction control unit with memory stalls, cycle counter and watchdog
module control_fsm
  import control_pkg::*;
#(
  parameter int INSTR_W    = 9,
  parameter int OP_W       = 5,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 0
) (
  input logic          clk,
  input logic          reset,
  control_fsm_if.slave bus
);
  localparam int WC_W = MEM_LAT > 2 ? $clog2(MEM_LAT - 1) : 1;
  state_t          r_state, w_next;
  logic [WC_W-1:0]  r_wcnt;
  logic [CNT_W-1:0] r_cnt;
  logic            r_timeout;
  logic [OP_W-1:0]  w_op;
  int unsigned     w_opc;
  logic            w_act, w_wd, w_mem, w_run, w_fin;
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("control_fsm: MEM_LAT must be at least 1");
  end
  assign w_op            = bus.instruction[INSTR_W-1 -: OP_W];
  assign w_opc           = 32'(w_op);
  assign bus.alu_op      = w_op;
  assign bus.pc_reset    = bus.req;
  assign bus.done        = r_state == IDLE;
  assign bus.timeout     = r_timeout;
  assign bus.cycle_count = r_cnt;
  always_comb begin
    w_act = r_state != IDLE;
    w_wd  = MAX_CYCLES != 0 && r_cnt == CNT_W'(MAX_CYCLES - 1);
    w_mem = w_opc == OP_LOADM || w_opc == OP_STOREM;
    w_run = w_act && !bus.req && !w_wd && r_state == RUN;
    w_fin = w_act && !bus.req && !w_wd && (r_state == WAIT ? r_wcnt == '0 : MEM_LAT == 1);
    bus.acc_src          = !(w_act && w_opc == OP_LOADM);
    bus.acc_write_enable = (w_run && (w_opc <= OP_ALU_MAX || w_opc == OP_LOADV || w_opc == OP_SLT))
                           || (w_fin && w_opc == OP_LOADM);
    bus.reg_write_enable = w_run && w_opc == OP_STOREV;
    bus.dat_write_enable = w_fin && w_opc == OP_STOREM;
    bus.compare_enable   = w_run && w_opc == OP_BEQ;
    bus.reljump_enable   = w_run && (w_opc == OP_BEQ || w_opc == OP_RB);
    bus.absjump_enable   = w_run && w_opc == OP_AB;
    bus.pc_enable        = w_mem ? w_fin : w_run && w_opc != OP_DONE;
    w_next = bus.req              ? RUN
           : !w_act || w_wd       ? IDLE
           : r_state == WAIT      ? (r_wcnt == '0 ? RUN : WAIT)
           : w_opc == OP_DONE     ? IDLE
           : w_mem && MEM_LAT > 1 ? WAIT
           : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wcnt    <= bus.req ? '0 : r_state == WAIT ? r_wcnt - WC_W'(1) : WC_W'(MEM_LAT - 2);
      r_cnt     <= bus.req ? '0 : (w_act && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
      r_timeout <= bus.req ? 1'b0 : r_timeout | (w_act && w_wd);
    end
  end
endmodule
